// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dmem_pkg;

    // Responder FSM encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int WORD_BYTES    = 4;
    localparam int BYTE_OFFSET_W = 2;

    // Ceiling log2, usable in constant expressions; clog2(1) = 0.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage : dmem_pkg

// File: rtl/dmem_array.sv
// Single-port DEPTH x DATA_W word storage, synchronous write, synchronous read.
// Latency: write commits on the enabled edge; read data appears after the enabled edge.
// Backpressure: none; the caller strobes i_we / i_re for exactly one cycle.
// Ports: clk, rst (async active-low, clears only the read register), i_we, i_re,
//        i_idx (word index), i_wdata, o_rdata (holds until the next read).
module dmem_array #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 32,
    parameter int IDX_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    // Storage is deliberately not reset.
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_idx] <= i_wdata;
        end
    end

    // Read-first: a read on the same edge as a write returns the old word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_idx];
        end
    end

    assign o_rdata = r_rdata;

endmodule : dmem_array

// File: rtl/dmem_responder.sv
// Responder end of the MEM-stage data-memory request/response interface.
// Latency: response valid LATENCY cycles after request accept; accepts spaced >= LATENCY+1 cycles.
// Backpressure: one request in flight; req_ready low until the response handshakes; response held stable while resp_ready is low.
// Ports: clk, rst (async active-low), req_valid/req_ready/req_we/req_addr/req_wdata (request),
//        resp_valid/resp_ready/resp_rdata/resp_err (response).
// Optional: define DMEM_ALIGN_CHECK_EN to flag misaligned requests on resp_err and suppress their access.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int IDX_W = clog2(DEPTH);
    localparam int CNT_W = (LATENCY > 1) ? clog2(LATENCY) : 1;

    if (LATENCY < 1) begin : g_bad_latency
        $error("dmem_responder: LATENCY must be at least 1");
    end
    if ((1 << IDX_W) != DEPTH) begin : g_bad_depth
        $error("dmem_responder: DEPTH must be a power of two");
    end

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_accept;
    logic               w_access;

    logic               r_we;
    logic [IDX_W-1:0]   r_idx;
    logic [DATA_W-1:0]  r_wdata;
    logic               r_rd_sel;
    logic               w_misal;
    logic [DATA_W-1:0]  w_arr_rdata;

    // Upper address bits beyond the index are intentionally dropped (address wrap).
    logic               w_unused_addr;
    assign w_unused_addr = ^req_addr;

    // ---------------------------------------------------------------------
    // FSM next state
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_access    = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_accept    = 1'b1;
                    w_cnt_nxt   = CNT_W'(LATENCY - 1);
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_access    = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // Request capture and response select
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we     <= 1'b0;
            r_idx    <= '0;
            r_wdata  <= '0;
            r_rd_sel <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we    <= req_we;
                r_idx   <= req_addr[IDX_W+BYTE_OFFSET_W-1:BYTE_OFFSET_W];
                r_wdata <= req_wdata;
            end
            // Only an aligned load exposes array data; stores and faulted
            // requests return zero.
            if (w_access) begin
                r_rd_sel <= !r_we && !w_misal;
            end
        end
    end

`ifdef DMEM_ALIGN_CHECK_EN
    logic r_misal;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_misal <= 1'b0;
        end else if (w_accept) begin
            r_misal <= (req_addr[BYTE_OFFSET_W-1:0] != '0);
        end
    end

    assign w_misal  = r_misal;
    assign resp_err = r_misal;
`else
    assign w_misal  = 1'b0;
    assign resp_err = 1'b0;
`endif

    // ---------------------------------------------------------------------
    // Storage: write and read both happen on the access edge, so a store
    // only commits if reset has not intervened before that edge.
    // ---------------------------------------------------------------------
    dmem_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_access && r_we && !w_misal),
        .i_re    (w_access && !r_we && !w_misal),
        .i_idx   (r_idx),
        .i_wdata (r_wdata),
        .o_rdata (w_arr_rdata)
    );

    assign req_ready  = (r_state == IDLE);
    assign resp_valid = (r_state == RESP);
    assign resp_rdata = r_rd_sel ? w_arr_rdata : '0;

endmodule : dmem_responder

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dmem_responder #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .DEPTH   (256),
        .LATENCY (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [16];
    int   n_vec;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
        end
    endtask

    // Waits (bounded) for resp_valid; returns cycles since the accept edge.
    task automatic wait_resp(output int n);
        n = 0;
        while (!resp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    // Full transaction; entered and left at #1 after a rising edge.
    task automatic run_vec(input int k);
        int    n;
        string nm;
        nm = $sformatf("vec%0d", k);
        check({nm, " req_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_we    = vecs[k].we;
        req_addr  = vecs[k].addr;
        req_wdata = vecs[k].wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check({nm, " valid_at_accept"}, {31'd0, resp_valid}, 32'd0);
        wait_resp(n);
        check({nm, " latency"}, n, LAT);
        check({nm, " rdata"}, resp_rdata, vecs[k].exp_rdata);
        check({nm, " err"}, {31'd0, resp_err}, {31'd0, vecs[k].exp_err});
        check({nm, " req_ready_busy"}, {31'd0, req_ready}, 32'd0);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check({nm, " valid_after_hs"}, {31'd0, resp_valid}, 32'd0);
        check({nm, " ready_after_hs"}, {31'd0, req_ready}, 32'd1);
    endtask

    task automatic add_vec(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] exp_rd, input logic exp_err);
        vecs[n_vec].we        = we;
        vecs[n_vec].addr      = addr;
        vecs[n_vec].wdata     = wd;
        vecs[n_vec].exp_rdata = exp_rd;
        vecs[n_vec].exp_err   = exp_err;
        n_vec++;
    endtask

    initial begin
        int n;
        int split;

        n_vec = 0;
        // Phase A
        add_vec(1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0);
        add_vec(1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0);
        add_vec(1'b1, 32'h3FC, 32'h0BADF00D, 32'h0,        1'b0);
        add_vec(1'b1, 32'h400, 32'h12345678, 32'h0,        1'b0);
        add_vec(1'b0, 32'h0,   32'h0,        32'h12345678, 1'b0);
        add_vec(1'b0, 32'h3FC, 32'h0,        32'h0BADF00D, 1'b0);
        add_vec(1'b1, 32'h20,  32'h11112222, 32'h0,        1'b0);
        split = n_vec;
        // Phase B (after backpressure and mid-operation reset sequences)
        add_vec(1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0);
        add_vec(1'b0, 32'h20,  32'h0,        32'h11112222, 1'b0);
`ifdef DMEM_ALIGN_CHECK_EN
        add_vec(1'b1, 32'h22,  32'hFFFF0000, 32'h0,        1'b1);
        add_vec(1'b0, 32'h20,  32'h0,        32'h11112222, 1'b0);
        add_vec(1'b0, 32'h21,  32'h0,        32'h0,        1'b1);
`else
        // Byte offset ignored: 0x23 reads word 0x20.
        add_vec(1'b0, 32'h23,  32'h0,        32'h11112222, 1'b0);
`endif

        rst        = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b0;

        // Reset
        repeat (3) @(posedge clk);
        #1;
        check("rst req_ready",  {31'd0, req_ready},  32'd1);
        check("rst resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst resp_rdata", resp_rdata,          32'd0);
        check("rst resp_err",   {31'd0, resp_err},   32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < split; k++) begin
            run_vec(k);
        end

        // Backpressure on a load; a store presented meanwhile must be ignored.
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h10;
        @(posedge clk); #1;
        req_we    = 1'b1;
        req_wdata = 32'h55555555;
        wait_resp(n);
        check("bp latency", n, LAT);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("bp%0d resp_valid", c), {31'd0, resp_valid}, 32'd1);
            check($sformatf("bp%0d rdata", c), resp_rdata, 32'hDEADBEEF);
            check($sformatf("bp%0d req_ready", c), {31'd0, req_ready}, 32'd0);
            @(posedge clk); #1;
        end
        req_valid  = 1'b0;
        check("bp held rdata", resp_rdata, 32'hDEADBEEF);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("bp valid_after_hs", {31'd0, resp_valid}, 32'd0);
        check("bp ready_after_hs", {31'd0, req_ready},  32'd1);

        // Reset during BUSY drops a pending store before its commit edge.
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'hAAAA5555;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("mr busy req_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("mr in_rst req_ready",  {31'd0, req_ready},  32'd1);
        check("mr in_rst resp_valid", {31'd0, resp_valid}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check($sformatf("mr%0d no_resp", c), {31'd0, resp_valid}, 32'd0);
        end

        for (int k = split; k < n_vec; k++) begin
            run_vec(k);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_dmem_responder
